// File: rtl/write_back_block.sv
// Write-back stage: registers the DM-stage result, commits it to a 32x8 register file
// one edge later, and serves two combinational read ports. WB_BYPASS_EN forwards the pending write.
module write_back_block #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk4,
  input  logic              rst,
  input  logic [DATA_W-1:0] mux_ans_dm,
  input  logic [ADDR_W-1:0] RW_dm,
  input  logic              wb_en_dm,
  input  logic [ADDR_W-1:0] RA_id,
  input  logic [ADDR_W-1:0] RB_id,
  output logic [DATA_W-1:0] A_id,
  output logic [DATA_W-1:0] B_id,
  output logic [DATA_W-1:0] ans_wb,
  output logic [ADDR_W-1:0] RW_wb,
  output logic              wb_en_wb,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              commit;

  assign commit = wb_en_wb && (RW_wb != '0);

  // A pending write still sitting in the stage register is dropped on reset.
  always_ff @(posedge clk4) begin
    if (rst) begin
      ans_wb     <= '0;
      RW_wb      <= '0;
      wb_en_wb   <= 1'b0;
      retire_cnt <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      ans_wb   <= mux_ans_dm;
      RW_wb    <= RW_dm;
      wb_en_wb <= wb_en_dm;
      if (commit) begin
        regs_q[RW_wb] <= ans_wb;
        if (retire_cnt != '1) begin
          retire_cnt <= retire_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    A_id = regs_q[RA_id];
    B_id = regs_q[RB_id];
`ifdef WB_BYPASS_EN
    if (commit && (RA_id == RW_wb)) A_id = ans_wb;
    if (commit && (RB_id == RW_wb)) B_id = ans_wb;
`endif
    // R0 is hardwired to zero, overriding any bypass.
    if (RA_id == '0) A_id = '0;
    if (RB_id == '0) B_id = '0;
  end

endmodule

// File: tb/tb_write_back_block.sv
// Scoreboard bench for write_back_block: driver pushes model predictions, monitor compares every cycle.
module tb_write_back_block;

  logic       clk4 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mux_ans_dm = '0;
  logic [4:0] RW_dm = '0;
  logic       wb_en_dm = 1'b0;
  logic [4:0] RA_id = '0;
  logic [4:0] RB_id = '0;
  logic [7:0] A_id, B_id, ans_wb;
  logic [4:0] RW_wb;
  logic       wb_en_wb;
  logic [15:0] retire_cnt;

  write_back_block dut (
    .clk4(clk4), .rst(rst), .mux_ans_dm(mux_ans_dm), .RW_dm(RW_dm), .wb_en_dm(wb_en_dm),
    .RA_id(RA_id), .RB_id(RB_id), .A_id(A_id), .B_id(B_id), .ans_wb(ans_wb),
    .RW_wb(RW_wb), .wb_en_wb(wb_en_wb), .retire_cnt(retire_cnt)
  );

  always #5 clk4 = ~clk4;

  typedef struct {
    logic [7:0]  ans;
    logic [4:0]  rw;
    logic        en;
    logic [15:0] cnt;
    logic [7:0]  a;
    logic [7:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents plus the one write waiting in WB.
  logic [7:0] m_regs [32];
  logic [7:0] m_ans;
  logic [4:0] m_rw;
  logic       m_en;
  int         m_cnt;

  function automatic logic [7:0] m_read(input logic [4:0] addr);
    if (addr == 0) return 8'h00;
`ifdef WB_BYPASS_EN
    if (m_en && m_rw == addr) return m_ans;
`endif
    return m_regs[addr];
  endfunction

  task automatic drive(input logic r, input logic [7:0] d, input logic [4:0] w,
                       input logic e, input logic [4:0] ra, input logic [4:0] rb);
    exp_t x;
    @(negedge clk4);
    rst = r; mux_ans_dm = d; RW_dm = w; wb_en_dm = e; RA_id = ra; RB_id = rb;
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
      m_ans = 8'h00; m_rw = 5'd0; m_en = 1'b0; m_cnt = 0;
    end else begin
      if (m_en && m_rw != 0) begin
        m_regs[m_rw] = m_ans;
        if (m_cnt < 65535) m_cnt++;
      end
      m_ans = d; m_rw = w; m_en = e;
    end
    x.ans = m_ans; x.rw = m_rw; x.en = m_en; x.cnt = 16'(m_cnt);
    x.a = m_read(ra); x.b = m_read(rb);
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk4);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("ans_wb", int'(ans_wb), int'(x.ans));
        chk("RW_wb", int'(RW_wb), int'(x.rw));
        chk("wb_en_wb", int'(wb_en_wb), int'(x.en));
        chk("retire_cnt", int'(retire_cnt), int'(x.cnt));
        chk("A_id", int'(A_id), int'(x.a));
        chk("B_id", int'(B_id), int'(x.b));
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    m_ans = 8'h00; m_rw = 5'd0; m_en = 1'b0; m_cnt = 0;

    // Reset, reads of R5 return zero
    drive(1, 8'h00, 5'd0, 0, 5'd5, 5'd5);
    drive(1, 8'h00, 5'd0, 0, 5'd5, 5'd5);
    // Write A5 to R3, observe latency on both ports
    drive(0, 8'hA5, 5'd3, 1, 5'd3, 5'd3);
    drive(0, 8'h00, 5'd0, 0, 5'd3, 5'd3);
    drive(0, 8'h00, 5'd0, 0, 5'd3, 5'd0);
    // Write to R0 is ignored and uncounted
    drive(0, 8'h7F, 5'd0, 1, 5'd0, 5'd0);
    drive(0, 8'h00, 5'd0, 0, 5'd0, 5'd0);
    drive(0, 8'h00, 5'd0, 0, 5'd0, 5'd3);
    // Back-to-back writes to R7
    drive(0, 8'h11, 5'd7, 1, 5'd7, 5'd7);
    drive(0, 8'h22, 5'd7, 1, 5'd7, 5'd7);
    drive(0, 8'h00, 5'd0, 0, 5'd7, 5'd7);
    drive(0, 8'h00, 5'd0, 0, 5'd7, 5'd3);
    // Disabled write still updates the stage register
    drive(0, 8'h5A, 5'd12, 0, 5'd12, 5'd7);
    drive(0, 8'h00, 5'd0, 0, 5'd12, 5'd12);
    // Capture 3C to R9, then reset discards it
    drive(0, 8'h3C, 5'd9, 1, 5'd9, 5'd9);
    drive(1, 8'h00, 5'd0, 0, 5'd9, 5'd7);
    drive(0, 8'h00, 5'd0, 0, 5'd9, 5'd3);
    drive(0, 8'h00, 5'd0, 0, 5'd9, 5'd9);

    // Randomized traffic on a narrow address range to force collisions
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), 8'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    // Counter saturation: more than 2**16 commits from a clean reset
    drive(1, 8'h00, 5'd0, 0, 5'd0, 5'd0);
    for (int n = 0; n < 65540; n++) begin
      drive(0, 8'($urandom), 5'($urandom_range(1, 31)), 1'b1,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    drive(0, 8'h00, 5'd0, 0, 5'd1, 5'd2);
    drive(0, 8'h00, 5'd0, 0, 5'd3, 5'd4);

    repeat (4) @(posedge clk4);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
